sobel_stream_px: RTL and testbench
==================================

// Module: sobel_stream_px
// PURPOSE
//  Streaming 3x3 Sobel edge detector, parametrised successor to the fixed 3-row/8-bit sobel core.
//  Accepts one raster-order pixel per beat (valid/ready), keeps two internal line buffers and a
//  3x3 window, and emits |Gx|+|Gy| magnitude (saturated, optionally inverted) for interior pixels.
//  Sits between the pixel source (camera/DMA) and the frame writer in the image pipeline.
// PARAMETERS
//  DATA_W  8    pixel width in bits (4..12)
//  IMG_W   640  pixels per line (>=3); line buffer depth
//  IMG_H   480  lines per frame (>=3)
//  INVERT  1    1: out = ~magnitude (dark edges on white); 0: out = magnitude
// PORTS
//  CLOCK      in   1        clock, rising edge
//  RESET      in   1        asynchronous, active-high reset
//  in_valid   in   1        input pixel valid
//  in_ready   out  1        block can accept input this cycle
//  in_sof     in   1        first pixel of frame (qualified by in_valid&in_ready)
//  in_pix     in   DATA_W   input pixel, unsigned
//  out_valid  out  1        output pixel valid
//  out_ready  in   1        downstream accepts output
//  out_last   out  1        last output pixel of frame
//  out_pix    out  DATA_W   edge magnitude
//  thresh     in   DATA_W   binarisation threshold (used only with SOBEL_THRESH_EN)
// BEHAVIOUR
//  Reset (async): out_valid=0, out_last=0, out_pix=0, col=row=0, pipeline valids=0; line buffer contents undefined.
//  Handshake: adv = ~out_valid | out_ready; in_ready = adv; all stages advance only on adv.
//   Beat accepted = in_valid & in_ready. Output held stable while out_valid & ~out_ready.
//  Counters: col 0..IMG_W-1, row 0..IMG_H-1, advance per accepted beat; col wraps -> row++; row wraps -> 0.
//   Accepted beat with in_sof=1 is pixel (0,0) regardless of counters (mid-frame restart);
//   in-flight outputs still drain, window and line-buffer history treated as empty.
//  Line buffers: LB0 holds row-1, LB1 holds row-2, indexed by col; read-before-write on each beat.
//  Window: 3 columns of {LB1[col], LB0[col], in_pix} shifted left each beat; w[r][c], c=2 newest.
//  Output generated for beat (row,col) only if row>=2 and col>=2; centre = (row-1,col-1).
//   Outputs per frame = (IMG_W-2)*(IMG_H-2); border pixels produce no output.
//  Arithmetic (signed, DATA_W+3 bits, no overflow):
//   Gx = (w00+2w10+w20) - (w02+2w12+w22); Gy = (w00+2w01+w02) - (w20+2w21+w22)
//   ax = min(|Gx|, 2^DATA_W-1); ay = min(|Gy|, 2^DATA_W-1); m = min(ax+ay, 2^DATA_W-1)
//   out_pix = INVERT ? ~m : m.
//  Pipeline: stage1 registers Gx,Gy + valid/last; stage2 registers out_pix/out_valid/out_last.
//   Latency = 2 cycles from accepting beat to out_valid with out_ready held high; throughput 1/cycle.
//  out_last = 1 with output for beat (IMG_H-1, IMG_W-1).
//  Stall with in_valid=0: no state change except output drain.
// CONFIGURATION
//  SOBEL_THRESH_EN defined: stage2 outputs out_pix = (m >= thresh) ? (INVERT?0:all-ones) : (INVERT?all-ones:0);
//   thresh sampled with the stage1->stage2 transfer.
//  SOBEL_THRESH_EN undefined: thresh port present but ignored; grey-level magnitude output as above.
// TESTING (DATA_W=8, IMG_W=8, IMG_H=6, INVERT=1 unless stated)
//  Flat frame all 100, out_ready=1 -> exactly 24 outputs all 0xFF, out_last only on 24th, first out_valid 2 cycles after beat (2,2).
//  Vertical step cols0-3=0, cols4-7=255 -> per output row: 0xFF,0xFF,0x00,0x00,0xFF,0xFF (centres col1..6).
//  Single pixel 40 at (2,3), rest 0 -> centre (2,2) m=80 -> out 0xAF; centre (1,3) m=80 -> out 0xAF.
//  out_ready toggled 1/0 random, in_valid random -> output sequence identical to unstalled run; out_pix stable while stalled.
//  RESET pulse mid-frame (row 3) then in_sof frame -> no stale outputs, next frame yields 24 correct outputs.
//  SOBEL_THRESH_EN, thresh=128, vertical-step frame -> edge centres 0x00, others 0xFF; thresh=0 -> all 0x00.

Source files
------------

// File: rtl/sobel_stream_px_if.sv
// Pixel stream bundle for sobel_stream_px: input pixel stream, output magnitude stream and threshold.
// The slave modport is the Sobel core's view; the master modport is the source/sink side.
interface sobel_stream_px_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [DATA_W-1:0] in_pix;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DATA_W-1:0] out_pix;
    logic [DATA_W-1:0] thresh;

    modport slave (
        input  in_valid, in_sof, in_pix, out_ready, thresh,
        output in_ready, out_valid, out_last, out_pix
    );

    modport master (
        output in_valid, in_sof, in_pix, out_ready, thresh,
        input  in_ready, out_valid, out_last, out_pix
    );
endinterface

// File: rtl/sobel_stream_px.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3x3 window, two-stage |Gx|+|Gy| pipeline.
// Optional feature macro SOBEL_THRESH_EN: binarise the magnitude against the thresh input.
module sobel_stream_px #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int INVERT = 1
) (
    input logic             CLOCK,
    input logic             RESET,
    sobel_stream_px_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DATA_W + 3;
    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] MAXV     = '1;

    // Handshake: a beat moves on either side only when valid & ready are both high at the
    // rising edge. Every stage advances together on adv, so in_ready is just "output slot free";
    // a presented output holds its value until it is taken.
    logic adv, acc;
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign acc          = bus.in_valid & adv;

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    assign cur_col = bus.in_sof ? '0 : col;
    assign cur_row = bus.in_sof ? '0 : row;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Line buffers and window carry no reset; the row/col gating keeps stale history out of outputs.
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] win [3][3];
    logic [DATA_W-1:0] nw  [3][3];

    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = lb1_rd;
        nw[1][2] = lb0_rd;
        nw[2][2] = bus.in_pix;
    end

    always_ff @(posedge CLOCK) begin
        if (acc) begin
            lb0[cur_col] <= bus.in_pix;
            lb1[cur_col] <= lb0_rd;
            win          <= nw;
        end
    end

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] x);
        return $signed({3'b000, x});
    endfunction

    function automatic logic [DATA_W-1:0] sat_abs(input logic signed [GW-1:0] g);
        logic [GW-1:0] a;
        a = g[GW-1] ? -g : g;
        return (a > {3'b000, MAXV}) ? MAXV : a[DATA_W-1:0];
    endfunction

    logic signed [GW-1:0] gx, gy;
    assign gx = (ext(nw[0][0]) + (ext(nw[1][0]) <<< 1) + ext(nw[2][0]))
              - (ext(nw[0][2]) + (ext(nw[1][2]) <<< 1) + ext(nw[2][2]));
    assign gy = (ext(nw[0][0]) + (ext(nw[0][1]) <<< 1) + ext(nw[0][2]))
              - (ext(nw[2][0]) + (ext(nw[2][1]) <<< 1) + ext(nw[2][2]));

    logic signed [GW-1:0] s1_gx, s1_gy;
    logic                 s1_valid, s1_last;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            s1_gx    <= '0;
            s1_gy    <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_gx    <= gx;
            s1_gy    <= gy;
            s1_valid <= acc & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
            s1_last  <= acc & (cur_row == ROW_LAST) & (cur_col == COL_LAST);
        end
    end

    logic [DATA_W:0]   mag_sum;
    logic [DATA_W-1:0] mag, pix_next;
    assign mag_sum = {1'b0, sat_abs(s1_gx)} + {1'b0, sat_abs(s1_gy)};
    assign mag     = mag_sum[DATA_W] ? MAXV : mag_sum[DATA_W-1:0];

`ifdef SOBEL_THRESH_EN
    // Edge hit maps to the "edge" colour: dark when inverted, bright otherwise.
    assign pix_next = ((mag >= bus.thresh) ^ (INVERT != 0)) ? MAXV : '0;
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh;
    assign pix_next      = (INVERT != 0) ? ~mag : mag;
`endif

    logic              o_valid, o_last;
    logic [DATA_W-1:0] o_pix;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_pix   <= '0;
        end else if (adv) begin
            o_valid <= s1_valid;
            o_last  <= s1_last;
            if (s1_valid) o_pix <= pix_next;
        end
    end

    assign bus.out_valid = o_valid;
    assign bus.out_last  = o_last;
    assign bus.out_pix   = o_pix;
endmodule

// File: tb/tb_sobel_stream_px.sv
// Self-checking bench for sobel_stream_px: random and directed frames against a frame-level Sobel model.
module tb_sobel_stream_px;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int INVERT = 1;
  localparam int FULL   = IMG_W * IMG_H;
  localparam int MAXV   = (1 << DATA_W) - 1;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  sobel_stream_px_if #(.DATA_W(DATA_W)) bus ();

  sobel_stream_px #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .INVERT(INVERT)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  // clock / reset
  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q[$];
  int img [IMG_H][IMG_W];
  bit rdy_random = 1'b0;
  int acc22_cyc = -1;
  int first_out_cyc = -1;
  logic [DATA_W-1:0] thr = 8'd128;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: whole-frame Sobel on the stored image
  function automatic logic [DATA_W-1:0] expect_pix(input int r, input int c);
    int gx, gy, ax, ay, m;
    gx = (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1])
       - (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1]);
    gy = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1])
       - (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ax > MAXV) ax = MAXV;
    if (ay > MAXV) ay = MAXV;
    m = ax + ay;
    if (m > MAXV) m = MAXV;
`ifdef SOBEL_THRESH_EN
    return ((m >= int'(thr)) != (INVERT != 0)) ? DATA_W'(MAXV) : '0;
`else
    return (INVERT != 0) ? DATA_W'(MAXV - m) : DATA_W'(m);
`endif
  endfunction

  // queue the outputs owed for the first k beats of the stored frame
  task automatic push_expected(input int k);
    for (int r = 1; r < IMG_H - 1; r++)
      for (int c = 1; c < IMG_W - 1; c++)
        if ((r + 1) * IMG_W + (c + 1) < k)
          exp_q.push_back({(r == IMG_H - 2 && c == IMG_W - 2), expect_pix(r, c)});
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (mode)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c < 4) ? 0 : 255;
          2:       img[r][c] = (r == 2 && c == 3) ? 40 : 0;
          3:       img[r][c] = $urandom_range(0, MAXV);
          default: img[r][c] = $urandom_range(100, 130);
        endcase
  endtask

  // driver tasks (called at posedge+#1)
  task automatic drive_pix(input int p, input bit sof, input int idle_max, output int acc_cyc);
    int  bound;
    bit  taken;
    repeat ($urandom_range(0, idle_max)) begin
      bus.in_valid = 1'b0;
      @(posedge CLOCK); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pix   = DATA_W'(p);
    bus.in_sof   = sof;
    bound = 0;
    acc_cyc = -1;
    forever begin
      @(negedge CLOCK);
      taken = bus.in_ready;
      @(posedge CLOCK); #1;
      if (taken) begin
        acc_cyc = cyc;
        break;
      end
      bound++;
      if (bound > 1000) begin
        check("accept_timeout", bound, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int k, input int idle_max);
    int ac;
    for (int i = 0; i < k; i++) begin
      drive_pix(img[i / IMG_W][i % IMG_W], (i == 0), idle_max, ac);
      if (i == 2 * IMG_W + 2) acc22_cyc = ac;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge CLOCK); #1;
      n++;
    end
    repeat (4) begin @(posedge CLOCK); #1; end
    check(tag, exp_q.size(), 0);
  endtask

  // downstream ready generator
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLOCK); #1;
      bus.out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard / monitor, sampled on the falling edge
  initial begin
    logic [DATA_W:0] held, got, e;
    bit holding;
    holding = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        holding = 1'b0;
        continue;
      end
      got = {bus.out_last, bus.out_pix};
      if (holding) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", got, held);
        holding = 1'b0;
      end
      if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("out_when_none_owed", bus.out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("out_last_pix", got, e);
        end
      end else if (bus.out_valid) begin
        holding = 1'b1;
        held    = got;
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pix   = '0;
    bus.thresh   = thr;
    RESET        = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_pix", bus.out_pix, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(posedge CLOCK); #1;

    // flat frame: all outputs flat, first output two cycles after beat (2,2) is presented
    fill(0);
    push_expected(FULL);
    first_out_cyc = -1;
    send_frame(FULL, 0);
    wait_drain("flat_drain");
    check("flat_latency", first_out_cyc, acc22_cyc + 1);

    // vertical step and single bright pixel
    fill(1); push_expected(FULL); send_frame(FULL, 0); wait_drain("step_drain");
    fill(2); push_expected(FULL); send_frame(FULL, 0); wait_drain("dot_drain");

    // random data with random input gaps and output back-pressure
    rdy_random = 1'b1;
    for (int f = 0; f < 4; f++) begin
      thr = DATA_W'($urandom_range(0, MAXV));
      bus.thresh = thr;
      fill((f % 2 == 0) ? 3 : 4);
      push_expected(FULL);
      send_frame(FULL, 2);
      wait_drain("rand_drain");
    end

    // mid-frame restart by in_sof: partial outputs drain, then a clean frame
    fill(3); push_expected(3 * IMG_W + 5); send_frame(3 * IMG_W + 5, 1);
    fill(4); push_expected(FULL); send_frame(FULL, 1);
    wait_drain("sof_restart_drain");

    // reset pulse during row 3, then a fresh frame
    fill(3); push_expected(3 * IMG_W + 3); send_frame(3 * IMG_W + 3, 1);
    #2;
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLOCK); #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_pix", bus.out_pix, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(posedge CLOCK); #1;
    fill(4); push_expected(FULL); send_frame(FULL, 1);
    wait_drain("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    check("global_timeout", 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
